// File: rtl/counter_pkg.sv
// Shared constants and the per-cell operation code for the multi-channel counter bank.
package counter_pkg;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_INC, OP_DEC} count_op_e;
endpackage

// File: rtl/counter_cell.sv
// One counter register with op decode, boundary detection and an overflow-set strobe.
module counter_cell
  import counter_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  count_op_e        op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf_set
);
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             at_max;
  logic             at_min;

  assign at_max = &count_reg;
  assign at_min = ~|count_reg;

  always_comb begin
    count_next = count_reg;
    ovf_set    = 1'b0;
    case (op)
      OP_LOAD: count_next = load_val;
      OP_INC: begin
        ovf_set = at_max;
        // In saturate mode the register simply stays pinned at the boundary.
        if (!(SATURATE != 0 && at_max))
          count_next = count_reg + WIDTH'(1);
      end
      OP_DEC: begin
        ovf_set = at_min;
        if (!(SATURATE != 0 && at_min))
          count_next = count_reg - WIDTH'(1);
      end
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign count = count_reg;
endmodule

// File: rtl/multi_chan_counter.sv
// Bank of CHANNELS counters: Slt routes load/count to one cell, Ovf flags are sticky per channel.
module multi_chan_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 2,
  parameter int SATURATE = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      En,
  input  logic [SEL_W-1:0]          Slt,
  input  logic                      Dir,
  input  logic                      Load,
  input  logic [WIDTH-1:0]          LoadVal,
  input  logic                      FlagClr,
  output logic [CHANNELS*WIDTH-1:0] Count_all,
  output logic [WIDTH-1:0]          Sel_count,
  output logic [CHANNELS-1:0]       Ovf
);
  logic [WIDTH-1:0]    counts [CHANNELS];
  logic [CHANNELS-1:0] ovf_set;
  logic [CHANNELS-1:0] ovf_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      count_op_e op;
      logic      hit;

      assign hit = (Slt == SEL_W'(gi));

      always_comb begin
        op = OP_HOLD;
        if (hit && Load)
          op = OP_LOAD;
        else if (hit && En)
          op = (Dir == DIR_DOWN) ? OP_DEC : OP_INC;
      end

      counter_cell #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
      ) u_cell (
        .Clk      (Clk),
        .Reset    (Reset),
        .op       (op),
        .load_val (LoadVal),
        .count    (counts[gi]),
        .ovf_set  (ovf_set[gi])
      );

      // A fresh overflow outranks a same-cycle flag clear.
      always_ff @(posedge Clk) begin
        if (Reset)
          ovf_reg[gi] <= 1'b0;
        else if (ovf_set[gi])
          ovf_reg[gi] <= 1'b1;
        else if (FlagClr)
          ovf_reg[gi] <= 1'b0;
      end

      assign Count_all[gi*WIDTH +: WIDTH] = counts[gi];
    end
  endgenerate

  // Out-of-range selects fall through to zero.
  always_comb begin
    Sel_count = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (Slt == SEL_W'(i))
        Sel_count = counts[i];
  end

  assign Ovf = ovf_reg;
endmodule

// File: tb/tb_multi_chan_counter.sv
// Scoreboard bench over four counter configurations; expectations queued after each edge.
module tb_multi_chan_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT index: 0 = W64/C2/wrap, 1 = W8/C2/wrap, 2 = W8/C2/saturate, 3 = W8/C3/wrap
  logic        rst  [4];
  logic        en   [4];
  logic        dir  [4];
  logic        load [4];
  logic        fclr [4];
  logic [1:0]  slt  [4];
  logic [63:0] lv   [4];

  logic [127:0] ca0;
  logic [15:0]  ca1, ca2;
  logic [23:0]  ca3;
  logic [63:0]  sel0;
  logic [7:0]   sel1, sel2, sel3;
  logic [1:0]   ovf0, ovf1, ovf2;
  logic [2:0]   ovf3;

  multi_chan_counter #(.WIDTH(64), .CHANNELS(2), .SATURATE(0)) u_d0 (
    .Clk(clk), .Reset(rst[0]), .En(en[0]), .Slt(slt[0][0]), .Dir(dir[0]), .Load(load[0]),
    .LoadVal(lv[0]), .FlagClr(fclr[0]), .Count_all(ca0), .Sel_count(sel0), .Ovf(ovf0));
  multi_chan_counter #(.WIDTH(8), .CHANNELS(2), .SATURATE(0)) u_d1 (
    .Clk(clk), .Reset(rst[1]), .En(en[1]), .Slt(slt[1][0]), .Dir(dir[1]), .Load(load[1]),
    .LoadVal(lv[1][7:0]), .FlagClr(fclr[1]), .Count_all(ca1), .Sel_count(sel1), .Ovf(ovf1));
  multi_chan_counter #(.WIDTH(8), .CHANNELS(2), .SATURATE(1)) u_d2 (
    .Clk(clk), .Reset(rst[2]), .En(en[2]), .Slt(slt[2][0]), .Dir(dir[2]), .Load(load[2]),
    .LoadVal(lv[2][7:0]), .FlagClr(fclr[2]), .Count_all(ca2), .Sel_count(sel2), .Ovf(ovf2));
  multi_chan_counter #(.WIDTH(8), .CHANNELS(3), .SATURATE(0)) u_d3 (
    .Clk(clk), .Reset(rst[3]), .En(en[3]), .Slt(slt[3]), .Dir(dir[3]), .Load(load[3]),
    .LoadVal(lv[3][7:0]), .FlagClr(fclr[3]), .Count_all(ca3), .Sel_count(sel3), .Ovf(ovf3));

  localparam int K_CNT = 0, K_OVF = 1, K_SEL = 2;

  typedef struct {
    int          d;
    int          kind;
    int          ch;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [63:0] actual(int d, int kind, int ch);
    logic [63:0] r;
    r = '0;
    case (d)
      0: r = (kind == K_CNT) ? ca0[ch*64 +: 64] : (kind == K_OVF) ? {62'd0, ovf0} : sel0;
      1: r = (kind == K_CNT) ? {56'd0, ca1[ch*8 +: 8]} : (kind == K_OVF) ? {62'd0, ovf1} : {56'd0, sel1};
      2: r = (kind == K_CNT) ? {56'd0, ca2[ch*8 +: 8]} : (kind == K_OVF) ? {62'd0, ovf2} : {56'd0, sel2};
      default: r = (kind == K_CNT) ? {56'd0, ca3[ch*8 +: 8]} : (kind == K_OVF) ? {61'd0, ovf3} : {56'd0, sel3};
    endcase
    return r;
  endfunction

  // Monitor: outputs are settled by the falling edge; drain everything queued since the rising edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      logic [63:0] a;
      me = q.pop_front();
      a  = actual(me.d, me.kind, me.ch);
      n_total++;
      if (a === me.val) begin
        n_pass++;
        $display("check %s dut%0d: %h ok", me.name, me.d, a);
      end else begin
        $display("FAIL %s dut%0d: actual %h required %h", me.name, me.d, a, me.val);
      end
    end
  end

  task automatic chk(int d, int kind, int ch, logic [63:0] v, string n);
    exp_t e;
    e.d = d; e.kind = kind; e.ch = ch; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  // Apply one cycle of stimulus to DUT d, then drop its strobes (Slt is kept for Sel_count).
  task automatic drv(int d, logic r, logic e, logic [1:0] s, logic di, logic l,
                     logic [63:0] v, logic fc);
    @(negedge clk); #1;
    rst[d] = r; en[d] = e; slt[d] = s; dir[d] = di; load[d] = l; lv[d] = v; fclr[d] = fc;
    @(posedge clk); #1;
    rst[d] = 1'b0; en[d] = 1'b0; dir[d] = 1'b0; load[d] = 1'b0; fclr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; en[i] = 1'b1; dir[i] = 1'b0; load[i] = 1'b0;
      fclr[i] = 1'b0; slt[i] = 2'd0; lv[i] = 64'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0;
    end
    chk(0, K_CNT, 0, 64'd0, "reset_d0_ch0");
    chk(0, K_CNT, 1, 64'd0, "reset_d0_ch1");
    chk(0, K_OVF, 0, 64'd0, "reset_d0_ovf");
    chk(0, K_SEL, 0, 64'd0, "reset_d0_sel");
    chk(3, K_CNT, 2, 64'd0, "reset_d3_ch2");
    chk(3, K_OVF, 0, 64'd0, "reset_d3_ovf");

    // Alternating select, 10 enabled cycles.
    for (int i = 0; i < 10; i++)
      drv(0, 1'b0, 1'b1, 2'(i % 2), 1'b0, 1'b0, 64'd0, 1'b0);
    chk(0, K_CNT, 0, 64'd5, "select_ch0");
    chk(0, K_CNT, 1, 64'd5, "select_ch1");
    chk(0, K_SEL, 0, 64'd5, "select_sel");
    chk(0, K_OVF, 0, 64'd0, "select_ovf");

    // Load outranks En.
    drv(0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 64'h1234, 1'b0);
    chk(0, K_CNT, 0, 64'h1234, "prio_load_over_en");
    chk(0, K_CNT, 1, 64'd5, "prio_other_holds");
    chk(0, K_SEL, 0, 64'h1234, "prio_sel");
    // Reset outranks Load.
    drv(0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 64'h1234, 1'b0);
    chk(0, K_CNT, 0, 64'd0, "prio_reset_ch0");
    chk(0, K_CNT, 1, 64'd0, "prio_reset_ch1");
    // 64-bit down-wrap from zero, then up-wrap back.
    drv(0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 64'd0, 1'b0);
    chk(0, K_CNT, 1, 64'hFFFF_FFFF_FFFF_FFFF, "w64_down_wrap");
    chk(0, K_OVF, 0, 64'd2, "w64_down_ovf");
    chk(0, K_SEL, 0, 64'hFFFF_FFFF_FFFF_FFFF, "w64_sel");
    drv(0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 64'd0, 1'b0);
    chk(0, K_CNT, 1, 64'd0, "w64_up_wrap");
    chk(0, K_OVF, 0, 64'd2, "w64_ovf_sticky");
    drv(0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 64'd0, 1'b1);
    chk(0, K_OVF, 0, 64'd0, "w64_flagclr");

    // 8-bit wrap on ch1.
    drv(1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 64'hFE, 1'b0);
    for (int i = 0; i < 3; i++)
      drv(1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 64'd0, 1'b0);
    chk(1, K_CNT, 1, 64'h01, "wrap_ch1");
    chk(1, K_CNT, 0, 64'h00, "wrap_ch0_holds");
    chk(1, K_OVF, 0, 64'd2, "wrap_ovf");
    chk(1, K_SEL, 0, 64'h01, "wrap_sel");
    drv(1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 64'd0, 1'b1);
    chk(1, K_OVF, 0, 64'd0, "wrap_flagclr");
    drv(1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 64'd0, 1'b0);
    drv(1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 64'd0, 1'b0);
    chk(1, K_CNT, 1, 64'hFF, "down_wrap_ch1");
    chk(1, K_OVF, 0, 64'd2, "down_wrap_ovf");
    drv(1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 64'hFF, 1'b0);
    chk(1, K_CNT, 0, 64'hFF, "load_ch0");
    chk(1, K_OVF, 0, 64'd2, "load_keeps_ovf");
    // Wrap on ch0 with FlagClr: ch1 bit clears, ch0 bit sets.
    drv(1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 64'd0, 1'b1);
    chk(1, K_CNT, 0, 64'h00, "clr_wrap_ch0");
    chk(1, K_OVF, 0, 64'd1, "clr_wrap_set_wins");

    // Saturation.
    for (int i = 0; i < 4; i++)
      drv(2, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    chk(2, K_CNT, 0, 64'h00, "sat_down_holds");
    chk(2, K_OVF, 0, 64'd1, "sat_down_ovf");
    drv(2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 64'hFF, 1'b0);
    chk(2, K_CNT, 0, 64'hFF, "sat_load");
    drv(2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 64'd0, 1'b1);
    chk(2, K_OVF, 0, 64'd0, "sat_flagclr");
    drv(2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    drv(2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk(2, K_CNT, 0, 64'hFF, "sat_up_holds");
    chk(2, K_OVF, 0, 64'd1, "sat_up_ovf");
    chk(2, K_CNT, 1, 64'h00, "sat_ch1_holds");
    drv(2, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 64'h02, 1'b0);
    drv(2, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 64'd0, 1'b0);
    chk(2, K_CNT, 1, 64'h01, "sat_normal_down");
    chk(2, K_OVF, 0, 64'd1, "sat_no_false_ovf");
    chk(2, K_SEL, 0, 64'h01, "sat_sel");

    // Out-of-range select on three channels.
    drv(3, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 64'd0, 1'b0);
    drv(3, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 64'd0, 1'b0);
    drv(3, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 64'h55, 1'b0);
    chk(3, K_CNT, 0, 64'd0, "oor_ch0");
    chk(3, K_CNT, 1, 64'd0, "oor_ch1");
    chk(3, K_CNT, 2, 64'd0, "oor_ch2");
    chk(3, K_SEL, 0, 64'd0, "oor_sel");
    drv(3, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 64'd0, 1'b0);
    chk(3, K_CNT, 2, 64'd1, "c3_ch2_inc");
    chk(3, K_SEL, 0, 64'd1, "c3_sel_ch2");
    drv(3, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 64'd0, 1'b0);
    chk(3, K_CNT, 2, 64'd1, "oor_ch2_holds");
    chk(3, K_SEL, 0, 64'd0, "oor_sel_zero");
    chk(3, K_OVF, 0, 64'd0, "oor_ovf");
    drv(3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 64'hAB, 1'b0);
    chk(3, K_CNT, 0, 64'hAB, "c3_load_ch0");
    chk(3, K_SEL, 0, 64'hAB, "c3_sel_ch0");

    @(negedge clk); #1;
    if (q.size() != 0) begin
      $display("FAIL drain: actual %0d pending required 0", q.size());
      n_total++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
